// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the round-robin memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_e;

  // Index width never drops below one bit, even for a single requester.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped as one bundle.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  localparam int IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic [IDX_W-1:0]       gnt_id;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_ready;
  logic                   mem_rvalid;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    output done, rdata, busy, gnt_id, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rvalid, mem_rdata,
    input  done, rdata, busy, gnt_id, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request bit at or after i_ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

  logic [NREQ-1:0] w_rot;
  logic [IDX_W:0]  w_ofs;
  logic [IDX_W:0]  w_sum;

  // Rotate so bit 0 is the pointer position, then find the lowest set bit.
  always_comb begin
    w_rot   = NREQ'({i_req, i_req} >> i_ptr);
    o_found = 1'b0;
    w_ofs   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_ofs   = (IDX_W+1)'(k);
      end
    end
    w_sum = {1'b0, i_ptr} + w_ofs;
    if (w_sum >= NREQ_W) begin
      w_sum = w_sum - NREQ_W;
    end
    o_idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among NREQ requesters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_l,
  mem_port_arbiter_if.slave bus
);

  localparam int             IDX_W    = idx_w(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [IDX_W-1:0]  r_gnt_id;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_pick_found;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [NREQ-1:0]   w_done;
  logic              w_mem_req;
  logic              w_busy;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_we    = bus.req_we[i];
        w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (w_pick_found)   w_next_state = ST_ISSUE;
      ST_ISSUE:     if (bus.mem_ready)  w_next_state = ST_WAIT_RESP;
      ST_WAIT_RESP: if (bus.mem_rvalid) w_next_state = ST_DONE;
      ST_DONE:                          w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = (r_state == ST_ISSUE);
    w_busy    = (r_state != ST_IDLE);
    w_done    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_done[i] = (r_state == ST_DONE) && (r_gnt_id == IDX_W'(i));
    end
  end

  // Request fields are captured only at grant; later requester changes are ignored.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_gnt_id <= '0;
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_pick_found) begin
        r_gnt_id <= w_pick_idx;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
      end
      if ((r_state == ST_WAIT_RESP) && bus.mem_rvalid && !r_we) begin
        r_rdata <= bus.mem_rdata;
      end
      if (r_state == ST_DONE) begin
        r_rr_ptr <= (r_gnt_id == LAST_IDX) ? '0 : r_gnt_id + IDX_W'(1);
      end
    end
  end

  assign bus.done      = w_done;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = w_busy;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-outstanding memory port between NREQ requesters such as the parameter-update, gradient and weight-load engines. Each requester drives a flat read/write request and receives a one-cycle done pulse with read data. Grants are issued round-robin and one transaction is in flight at a time. The block sits between the FPU-side engines and the memory controller, so several engines can run against a single memory port.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request, level, held until its done
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ×ADDR_W  per-requester address
- req_wdata  in  NREQ×DATA_W  per-requester write data
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while any done bit is high
- busy  out  1  transaction in flight (state ≠ IDLE)
- gnt_id  out  $clog2(NREQ)  currently granted requester
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response/ack; carries read data, also acknowledges writes
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr_ptr (wrapping modulo NREQ).
  - Latch its index into gnt_id, and latch we/addr/wdata into registers.
  - Go to ISSUE.
- ISSUE: mem_req=1 with the latched fields. On mem_ready=1, go to WAIT_RESP.
- WAIT_RESP:
  - On mem_rvalid=1, register mem_rdata into rdata (reads only; writes leave rdata unchanged).
  - Go to DONE.
- DONE:
  - done[gnt_id]=1 for exactly one cycle.
  - rr_ptr ← (gnt_id+1) mod NREQ.
  - Return to IDLE. No arbitration happens in this cycle.
- Requester rule: a requester deasserts req_valid by the edge that ends its done cycle. A still-high valid in the following IDLE is treated as a new request.
- A requester dropping req_valid mid-transaction does not abort it. The transaction completes and done still pulses.
- mem_rvalid outside WAIT_RESP is ignored.
- Request fields are sampled only at grant. Later changes to req_addr/req_wdata have no effect.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, gnt_id=0.
  - done=0, rdata=0, busy=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-transaction: immediate return to reset values. No done is issued, and the memory side is abandoned.
- All outputs are registered or decoded from state/registers. There is no combinational path from req_valid to mem_req.
- Minimum latency, with valid sampled in IDLE at cycle 0:
  - mem_req is high in cycle 1.
  - With mem_ready in cycle 1 and mem_rvalid in cycle 2, done is high in cycle 3.
- Back-to-back throughput: 4 cycles per transaction.
- mem_req is held, with stable addr/we/wdata, until mem_ready is sampled high.
- Fairness: with all NREQ requesting continuously, each is granted once every NREQ transactions.

## Structure
- Package mem_arb_pkg: state enum typedef, default width constants, and an index-width helper (`$clog2(NREQ)`, minimum 1).
- Sub-module rr_picker: combinational; inputs req vector and ptr; outputs found flag and index of the first set bit at or after ptr, wrapping.
- Top level holds the FSM, latched request registers, rr_ptr and the rdata register.

## Test plan
- Single read: req_valid=0001, addr=0x40, mem_ready in cycle 1, rvalid in cycle 2 with 0xDEADBEEF -> done=0001 in cycle 3, rdata=0xDEADBEEF.
- All four requesting continuously after reset -> grants 0,1,2,3,0 in order, exactly one done bit per 4-cycle transaction.
- Write with mem_ready held low 5 cycles -> mem_req stays high and mem_addr/mem_wdata stay stable; done follows 2 cycles after the ready cycle; rdata unchanged.
- Requester 2 drops req_valid in ISSUE -> transaction completes, done=0100. Spurious mem_rvalid during ISSUE is ignored.
- Requests 1 and 3 pending with rr_ptr=2 -> requester 3 is granted first, then 1.
- rst_l pulsed low during WAIT_RESP -> all outputs at reset values, no done pulse; the next request is arbitrated from rr_ptr=0.
